// File: rtl/proj_router_buffer.sv
// -----------------------------------------------------------------------------
// proj_router_buffer
//
// Routes projection words coming out of the tracklet projection calculator.
//   * Local projections are written into an external double-paged projection
//     memory (one page per event).  This block drives the write port and keeps
//     the per-page entry count, reporting the count of each page as it closes.
//   * Plus / minus neighbour projections are pushed into two independent
//     first-word-fall-through FIFOs drained by the neighbour-sector links
//     with a valid/ready handshake.
//
// Ports
//   clk, reset                  processing clock, asynchronous active-high reset
//   en_proc                     input-side enable (gates writes and pushes)
//   start                       event boundary pulse, swaps the local page
//   projection                  projection word {TC_index, index, phi, z, phider, zder}
//   valid_proj                  write word to local memory
//   valid_projPlus/Minus        push word to plus / minus FIFO
//   mem_wr_en/addr/data         registered local memory write port, addr = {page, entry}
//   nentries, nentries_page     entry count and page id of the page just closed
//   local_ovf                   sticky: local page full, word dropped (clears on start)
//   plus_* / minus_*            FIFO head, valid, ready, occupancy and sticky overflow
// -----------------------------------------------------------------------------
module proj_router_buffer #(
   parameter int DATA_WIDTH  = 54,
   parameter int LOCAL_ABITS = 6,
   parameter int FIFO_ABITS  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_proc,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   projection,
   input  logic                    valid_proj,
   input  logic                    valid_projPlus,
   input  logic                    valid_projMinus,
   output logic                    mem_wr_en,
   output logic [LOCAL_ABITS:0]    mem_wr_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   output logic [LOCAL_ABITS:0]    nentries,
   output logic                    nentries_page,
   output logic                    local_ovf,
   output logic [DATA_WIDTH-1:0]   plus_dout,
   output logic                    plus_valid,
   input  logic                    plus_ready,
   output logic [DATA_WIDTH-1:0]   minus_dout,
   output logic                    minus_valid,
   input  logic                    minus_ready,
   output logic                    plus_ovf,
   output logic                    minus_ovf,
   output logic [FIFO_ABITS:0]     plus_count,
   output logic [FIFO_ABITS:0]     minus_count
);

   localparam logic [LOCAL_ABITS:0] LOCAL_DEPTH = (LOCAL_ABITS+1)'(1) << LOCAL_ABITS;
   localparam logic [FIFO_ABITS:0]  FIFO_DEPTH  = (FIFO_ABITS+1)'(1) << FIFO_ABITS;
   localparam int                   FIFO_WORDS  = 1 << FIFO_ABITS;

   // -------------------------------------------------------------------------
   // Local path
   // -------------------------------------------------------------------------
   logic                   page_reg;
   logic [LOCAL_ABITS:0]   count_reg;
   logic                   mem_wr_en_reg;
   logic [LOCAL_ABITS:0]   mem_wr_addr_reg;
   logic [DATA_WIDTH-1:0]  mem_wr_data_reg;
   logic [LOCAL_ABITS:0]   nentries_reg;
   logic                   nentries_page_reg;
   logic                   local_ovf_reg;

   // A word arriving together with start belongs to the new event, so the
   // page/count it sees are those the page swap is about to produce.
   logic                   eff_page;
   logic [LOCAL_ABITS:0]   eff_count;
   logic                   local_req;
   logic                   local_acc;
   logic                   local_drop;
   logic [LOCAL_ABITS:0]   count_next;

   always_comb begin
      eff_page   = start ? ~page_reg : page_reg;
      eff_count  = start ? '0 : count_reg;
      local_req  = en_proc & valid_proj;
      local_acc  = local_req & (eff_count != LOCAL_DEPTH);
      local_drop = local_req & ~local_acc;
      count_next = eff_count + (LOCAL_ABITS+1)'(local_acc);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page_reg          <= 1'b0;
         count_reg         <= '0;
         mem_wr_en_reg     <= 1'b0;
         mem_wr_addr_reg   <= '0;
         mem_wr_data_reg   <= '0;
         nentries_reg      <= '0;
         nentries_page_reg <= 1'b0;
         local_ovf_reg     <= 1'b0;
      end else begin
         mem_wr_en_reg <= local_acc;
         if (local_acc) begin
            mem_wr_addr_reg <= {eff_page, eff_count[LOCAL_ABITS-1:0]};
            mem_wr_data_reg <= projection;
         end

         // Counter saturates at LOCAL_DEPTH because local_acc is blocked there.
         count_reg <= count_next;

         if (start) begin
            nentries_reg      <= count_reg;
            nentries_page_reg <= page_reg;
            page_reg          <= ~page_reg;
         end

         // A drop can only happen without start (start empties the count).
         if (start)
            local_ovf_reg <= 1'b0;
         else if (local_drop)
            local_ovf_reg <= 1'b1;
      end
   end

   assign mem_wr_en     = mem_wr_en_reg;
   assign mem_wr_addr   = mem_wr_addr_reg;
   assign mem_wr_data   = mem_wr_data_reg;
   assign nentries      = nentries_reg;
   assign nentries_page = nentries_page_reg;
   assign local_ovf     = local_ovf_reg;

   // -------------------------------------------------------------------------
   // Neighbour FIFOs: lane 0 = plus, lane 1 = minus.
   //
   // The head word lives in dout_reg (a registered copy of mem[rd_ptr]) so
   // the consumer sees a registered output.  On a pop the next head is loaded
   // from mem[rd_ptr+1]; when only one word is stored, the next head can only
   // be the word being pushed in the same cycle.
   // -------------------------------------------------------------------------
   logic [1:0]              fifo_push_flag;
   logic [1:0]              fifo_ready;
   logic [1:0]              fifo_valid;
   logic [1:0]              fifo_ovf;
   logic [DATA_WIDTH-1:0]   fifo_dout  [2];
   logic [FIFO_ABITS:0]     fifo_count [2];

   assign fifo_push_flag = {valid_projMinus, valid_projPlus};
   assign fifo_ready     = {minus_ready, plus_ready};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
         logic [DATA_WIDTH-1:0] mem [FIFO_WORDS];
         logic [FIFO_ABITS-1:0] wr_ptr_reg;
         logic [FIFO_ABITS-1:0] rd_ptr_reg;
         logic [FIFO_ABITS:0]   count_reg;
         logic [DATA_WIDTH-1:0] dout_reg;
         logic                  ovf_reg;

         logic                  pop;
         logic                  push_req;
         logic                  push_acc;
         logic                  push_drop;
         logic [FIFO_ABITS-1:0] rd_ptr_next;
         logic [FIFO_ABITS:0]   count_next;

         always_comb begin
            pop         = (count_reg != '0) & fifo_ready[gi];
            push_req    = en_proc & fifo_push_flag[gi];
            // When full, a simultaneous pop frees the slot the push needs.
            push_acc    = push_req & ((count_reg != FIFO_DEPTH) | pop);
            push_drop   = push_req & ~push_acc;
            rd_ptr_next = rd_ptr_reg + 1'b1;
            count_next  = count_reg;
            if (push_acc && !pop)
               count_next = count_reg + 1'b1;
            else if (!push_acc && pop)
               count_next = count_reg - 1'b1;
         end

         // Storage array without reset so it maps onto RAM primitives;
         // the pointers being reset is what discards buffered data.
         always_ff @(posedge clk) begin
            if (push_acc)
               mem[wr_ptr_reg] <= projection;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               dout_reg   <= '0;
               ovf_reg    <= 1'b0;
            end else begin
               if (push_acc)
                  wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (pop)
                  rd_ptr_reg <= rd_ptr_next;
               count_reg <= count_next;

               if (pop) begin
                  if (count_reg == (FIFO_ABITS+1)'(1)) begin
                     if (push_acc)
                        dout_reg <= projection;
                  end else begin
                     dout_reg <= mem[rd_ptr_next];
                  end
               end else if (count_reg == '0 && push_acc) begin
                  dout_reg <= projection;
               end

               // A drop in the start cycle still marks the new event.
               if (push_drop)
                  ovf_reg <= 1'b1;
               else if (start)
                  ovf_reg <= 1'b0;
            end
         end

         assign fifo_valid[gi] = (count_reg != '0);
         assign fifo_ovf[gi]   = ovf_reg;
         assign fifo_dout[gi]  = dout_reg;
         assign fifo_count[gi] = count_reg;
      end
   endgenerate

   assign plus_dout   = fifo_dout[0];
   assign plus_valid  = fifo_valid[0];
   assign plus_count  = fifo_count[0];
   assign plus_ovf    = fifo_ovf[0];
   assign minus_dout  = fifo_dout[1];
   assign minus_valid = fifo_valid[1];
   assign minus_count = fifo_count[1];
   assign minus_ovf   = fifo_ovf[1];

endmodule

// File: tb/tb_proj_router_buffer.sv
// -----------------------------------------------------------------------------
// tb_proj_router_buffer
//
// Directed bench for proj_router_buffer: local page writes and reporting,
// page overflow, start/valid collisions, neighbour FIFO fill / drain /
// overflow / push-with-pop, en_proc gating and asynchronous reset.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_proj_router_buffer;

   localparam int DW = 54;
   localparam int LA = 6;
   localparam int FA = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            en_proc;
   logic            start;
   logic [DW-1:0]   projection;
   logic            valid_proj;
   logic            valid_projPlus;
   logic            valid_projMinus;
   logic            mem_wr_en;
   logic [LA:0]     mem_wr_addr;
   logic [DW-1:0]   mem_wr_data;
   logic [LA:0]     nentries;
   logic            nentries_page;
   logic            local_ovf;
   logic [DW-1:0]   plus_dout;
   logic            plus_valid;
   logic            plus_ready;
   logic [DW-1:0]   minus_dout;
   logic            minus_valid;
   logic            minus_ready;
   logic            plus_ovf;
   logic            minus_ovf;
   logic [FA:0]     plus_count;
   logic [FA:0]     minus_count;

   int checks   = 0;
   int failures = 0;

   proj_router_buffer #(
      .DATA_WIDTH (DW),
      .LOCAL_ABITS(LA),
      .FIFO_ABITS (FA)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en_proc        (en_proc),
      .start          (start),
      .projection     (projection),
      .valid_proj     (valid_proj),
      .valid_projPlus (valid_projPlus),
      .valid_projMinus(valid_projMinus),
      .mem_wr_en      (mem_wr_en),
      .mem_wr_addr    (mem_wr_addr),
      .mem_wr_data    (mem_wr_data),
      .nentries       (nentries),
      .nentries_page  (nentries_page),
      .local_ovf      (local_ovf),
      .plus_dout      (plus_dout),
      .plus_valid     (plus_valid),
      .plus_ready     (plus_ready),
      .minus_dout     (minus_dout),
      .minus_valid    (minus_valid),
      .minus_ready    (minus_ready),
      .plus_ovf       (plus_ovf),
      .minus_ovf      (minus_ovf),
      .plus_count     (plus_count),
      .minus_count    (minus_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one clock; returns 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [DW-1:0] WA = 54'h00_1111_AAAA_0001;
   localparam logic [DW-1:0] WB = 54'h00_2222_BBBB_0002;
   localparam logic [DW-1:0] WC = 54'h00_3333_CCCC_0003;
   localparam logic [DW-1:0] WD = 54'h3F_DDDD_DDDD_DDDD;
   localparam logic [DW-1:0] WE = 54'h15_EEEE_EEEE_0005;
   localparam logic [DW-1:0] WX = 54'h2A_5A5A_5A5A_5A5A;
   localparam logic [DW-1:0] PB = 54'h10_0000_0000_0100;
   localparam logic [DW-1:0] MB = 54'h20_0000_0000_0200;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; en_proc = 1'b0; start = 1'b0; projection = '0;
      valid_proj = 1'b0; valid_projPlus = 1'b0; valid_projMinus = 1'b0;
      plus_ready = 1'b0; minus_ready = 1'b0;
      tick(); tick();

      // ---- reset state ----
      check("rst_mem_wr_en",   64'(mem_wr_en), 64'h0);
      check("rst_mem_wr_addr", 64'(mem_wr_addr), 64'h0);
      check("rst_mem_wr_data", 64'(mem_wr_data), 64'h0);
      check("rst_nentries",    64'(nentries), 64'h0);
      check("rst_local_ovf",   64'(local_ovf), 64'h0);
      check("rst_plus_valid",  64'(plus_valid), 64'h0);
      check("rst_minus_count", 64'(minus_count), 64'h0);
      check("rst_plus_dout",   64'(plus_dout), 64'h0);
      reset = 1'b0;

      // ---- three local words A,B,C then start ----
      en_proc = 1'b1; valid_proj = 1'b1; projection = WA;
      tick();
      check("A_wr_en",   64'(mem_wr_en), 64'h1);
      check("A_wr_addr", 64'(mem_wr_addr), 64'h00);
      check("A_wr_data", 64'(mem_wr_data), 64'(WA));
      projection = WB;
      tick();
      check("B_wr_addr", 64'(mem_wr_addr), 64'h01);
      check("B_wr_data", 64'(mem_wr_data), 64'(WB));
      projection = WC;
      tick();
      check("C_wr_addr", 64'(mem_wr_addr), 64'h02);
      check("C_wr_data", 64'(mem_wr_data), 64'(WC));
      valid_proj = 1'b0;
      tick();
      check("C_idle_wr_en", 64'(mem_wr_en), 64'h0);
      start = 1'b1;
      tick();
      check("abc_nentries", 64'(nentries), 64'd3);
      check("abc_nent_page", 64'(nentries_page), 64'h0);
      start = 1'b0; valid_proj = 1'b1; projection = WE;
      tick();
      check("page1_wr_en",   64'(mem_wr_en), 64'h1);
      check("page1_wr_addr", 64'(mem_wr_addr), 64'h40);
      valid_proj = 1'b0;
      start = 1'b1;                     // close page 1 (1 entry), back to page 0
      tick();
      check("page1_nentries", 64'(nentries), 64'd1);
      check("page1_nent_page", 64'(nentries_page), 64'h1);
      start = 1'b0;

      // ---- 65 words into page 0: 64 written, 65th dropped ----
      for (int i = 0; i < 65; i++) begin
         valid_proj = 1'b1; projection = DW'(i) | WD;
         tick();
         if (i < 64) begin
            check($sformatf("fill_addr_%0d", i), 64'(mem_wr_addr), 64'(i));
            check($sformatf("fill_en_%0d", i), 64'(mem_wr_en), 64'h1);
         end else begin
            check("fill_65_wr_en", 64'(mem_wr_en), 64'h0);
            check("fill_65_ovf", 64'(local_ovf), 64'h1);
         end
      end
      valid_proj = 1'b0; start = 1'b1;
      tick();
      check("full_nentries", 64'(nentries), 64'd64);
      check("full_nent_page", 64'(nentries_page), 64'h0);
      check("full_ovf_clr", 64'(local_ovf), 64'h0);
      // back-to-back start: page 1 closes empty
      tick();
      check("b2b_nentries", 64'(nentries), 64'd0);
      check("b2b_nent_page", 64'(nentries_page), 64'h1);
      start = 1'b0;

      // ---- 5 writes, then start together with D ----
      for (int i = 0; i < 5; i++) begin
         valid_proj = 1'b1; projection = DW'(i + 100);
         tick();
      end
      check("five_last_addr", 64'(mem_wr_addr), 64'h04);
      start = 1'b1; projection = WD;
      tick();
      check("startD_nentries", 64'(nentries), 64'd5);
      check("startD_nent_page", 64'(nentries_page), 64'h0);
      check("startD_wr_en", 64'(mem_wr_en), 64'h1);
      check("startD_wr_addr", 64'(mem_wr_addr), 64'h40);
      check("startD_wr_data", 64'(mem_wr_data), 64'(WD));
      valid_proj = 1'b0;
      tick();                            // start still high: closes page 1
      check("startD_next_nent", 64'(nentries), 64'd1);
      check("startD_next_page", 64'(nentries_page), 64'h1);
      start = 1'b0;

      // ---- en_proc low gates everything; start still swaps ----
      en_proc = 1'b0; valid_proj = 1'b1; valid_projPlus = 1'b1; valid_projMinus = 1'b1;
      projection = WX;
      tick();
      check("noen_wr_en", 64'(mem_wr_en), 64'h0);
      check("noen_plus_count", 64'(plus_count), 64'h0);
      check("noen_minus_count", 64'(minus_count), 64'h0);
      valid_proj = 1'b0; valid_projPlus = 1'b0; valid_projMinus = 1'b0;
      start = 1'b1;
      tick();
      check("noen_start_page", 64'(nentries_page), 64'h0);
      start = 1'b0; en_proc = 1'b1; valid_proj = 1'b1;
      tick();
      check("noen_start_addr", 64'(mem_wr_addr), 64'h40);
      valid_proj = 1'b0;

      // ---- plus FIFO: fill 16, overflow 17th, drain in order ----
      for (int i = 0; i < 17; i++) begin
         valid_projPlus = 1'b1; projection = PB + DW'(i);
         tick();
         if (i == 0) begin
            check("plus_first_valid", 64'(plus_valid), 64'h1);
            check("plus_first_dout", 64'(plus_dout), 64'(PB));
         end
         if (i == 15) begin
            check("plus_16_count", 64'(plus_count), 64'd16);
            check("plus_16_ovf", 64'(plus_ovf), 64'h0);
         end
      end
      check("plus_17_count", 64'(plus_count), 64'd16);
      check("plus_17_ovf", 64'(plus_ovf), 64'h1);
      valid_projPlus = 1'b0; plus_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("plus_pop_%0d", i), 64'(plus_dout), 64'(PB + DW'(i)));
         tick();
      end
      check("plus_drained_valid", 64'(plus_valid), 64'h0);
      check("plus_drained_count", 64'(plus_count), 64'h0);
      check("plus_hold_dout", 64'(plus_dout), 64'(PB + DW'(15)));
      plus_ready = 1'b0;
      start = 1'b1;
      tick();
      check("plus_ovf_start_clr", 64'(plus_ovf), 64'h0);
      start = 1'b0;

      // ---- minus FIFO: full, push and pop in the same cycle ----
      for (int i = 0; i < 16; i++) begin
         valid_projMinus = 1'b1; projection = MB + DW'(i);
         tick();
      end
      check("minus_full_count", 64'(minus_count), 64'd16);
      projection = WX; minus_ready = 1'b1;
      tick();
      check("minus_pp_count", 64'(minus_count), 64'd16);
      check("minus_pp_ovf", 64'(minus_ovf), 64'h0);
      valid_projMinus = 1'b0;
      for (int i = 1; i < 16; i++) begin
         check($sformatf("minus_pop_%0d", i), 64'(minus_dout), 64'(MB + DW'(i)));
         tick();
      end
      check("minus_tail_dout", 64'(minus_dout), 64'(WX));
      check("minus_tail_count", 64'(minus_count), 64'd1);
      tick();
      check("minus_empty_valid", 64'(minus_valid), 64'h0);
      minus_ready = 1'b0;

      // ---- asynchronous reset mid-burst ----
      valid_proj = 1'b1; valid_projPlus = 1'b1; projection = WB;
      tick(); tick();
      check("pre_rst_plus_count", 64'(plus_count), 64'd2);
      check("pre_rst_wr_en", 64'(mem_wr_en), 64'h1);
      #2 reset = 1'b1;
      #1;
      check("arst_wr_en", 64'(mem_wr_en), 64'h0);
      check("arst_wr_addr", 64'(mem_wr_addr), 64'h0);
      check("arst_wr_data", 64'(mem_wr_data), 64'h0);
      check("arst_nentries", 64'(nentries), 64'h0);
      check("arst_plus_count", 64'(plus_count), 64'h0);
      check("arst_plus_valid", 64'(plus_valid), 64'h0);
      check("arst_plus_dout", 64'(plus_dout), 64'h0);
      check("arst_minus_dout", 64'(minus_dout), 64'h0);
      valid_proj = 1'b0; valid_projPlus = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
